ub_host_link: RTL
=================

Name: ub_host_link

Overview:
- Host-side partner of the unified buffer. Acts as the writer for the buffer's host-load port and the reader for its product-matrix output stream.
- Load path: accepts a byte stream from chip pins and drives fetch_inp, dma_address and ui_in, one byte per accepted host beat.
- Read path: issues a one-cycle ext request, then captures the 4-byte final_out burst and re-presents it to the pins with a valid strobe.

Parameters:
- MEM_SIZE, 16, unified buffer depth in bytes; dma_address wraps modulo MEM_SIZE.
- BURST_LEN, 4, bytes per product-matrix read burst.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- load_start  in  1  pulse: begin a load of load_len bytes at load_base
- load_base  in  4  first buffer address of the load
- load_len  in  5  bytes to load, 1..16; 0 is ignored
- host_valid  in  1  host byte present on host_data
- host_data  in  8  host byte
- host_ready  out  1  high while LOAD can accept a byte
- load_done  out  1  one-cycle pulse after the last byte is written
- read_req  in  1  pulse: read a product matrix at read_addr
- read_addr  in  4  buffer base address of the product matrix
- fetch_inp  out  1  buffer write strobe
- dma_address  out  4  buffer write address
- ui_in  out  8  buffer write data
- ext  out  1  buffer read-out request
- ub_addr  out  5  buffer address bus; carries read_addr zero-extended
- final_out  in  8  buffer read-out byte
- out_valid  out  1  out_data holds a captured byte
- out_data  out  8  captured byte
- busy  out  1  FSM not in IDLE
- rd_err  out  1  one-cycle pulse: read rejected

Behaviour:
- Reset: all outputs 0; FSM to IDLE; counters cleared. A reset mid-load or mid-read abandons the transfer with no done or valid pulses.
- All outputs are registered.
- FSM states: IDLE, LOAD, RD_ISSUE, RD_WAIT, RD_CAPTURE.
- IDLE transitions:
  - load_start with load_len != 0 → LOAD; latch ptr = load_base and remaining = load_len.
  - Otherwise read_req → RD_ISSUE.
  - load_start wins if both are asserted in the same cycle; that read_req is dropped.
  - read_req with read_addr > MEM_SIZE-BURST_LEN (>12): pulse rd_err and stay in IDLE.
- LOAD:
  - host_ready = 1.
  - Each cycle host_valid=1: next cycle fetch_inp=1, dma_address=ptr, ui_in=host_data. Then ptr += 1 (wraps 15→0) and remaining -= 1.
  - fetch_inp is 0 in cycles with no accepted byte.
  - On acceptance of the last byte, host_ready drops the next cycle. load_done pulses in the same cycle as the final fetch_inp. Return to IDLE.
  - read_req during LOAD is ignored.
- Read timing (C0 = cycle ext is high):
  - RD_ISSUE: ext=1 and ub_addr=read_addr for exactly one cycle (C0). ub_addr holds until the return to IDLE.
  - RD_WAIT: C1.
  - RD_CAPTURE: C2..C5. Sample final_out at the end of each cycle, giving byte k of 4.
  - out_valid=1 with out_data=byte k during C3..C6.
  - Return to IDLE at the end of C5. A new ext may be issued no earlier than C6, which matches buffer re-arm.
- load_start and read_req are ignored while busy.
- out_data holds its last value when out_valid=0.

Decomposition:
- Package ub_link_pkg:
  - state_t enum (IDLE, LOAD, RD_ISSUE, RD_WAIT, RD_CAPTURE)
  - MEM_SIZE, BURST_LEN
  - RD_LAT = 2 (cycles from ext to first valid final_out)
- No sub-module. A single FSM with a 5-bit remaining counter and a 2-bit capture counter.

Test Plan:
- Load: load_start, base=0, len=4; host bytes 0x11,0x22,0x33,0x44 back-to-back → fetch_inp for 4 consecutive cycles at addresses 0..3 with matching ui_in; load_done coincides with the 4th write; host_ready low afterwards.
- Wrap and stall: base=14, len=4, host_valid toggled 1,0,1,1,0,1 with bytes 0xA0..0xA3 → writes land at addresses 14,15,0,1; fetch_inp is 0 in stall cycles.
- Read: preload the bench buffer model with 0x05,0x06,0x07,0x08 at addr 8; read_req addr=8 → ext pulses once with ub_addr=8; out_valid for exactly 4 cycles starting 3 cycles after ext, carrying 0x05..0x08.
- Back-to-back reads: issue read_req every cycle at addr 0 → second ext appears exactly 6 cycles after the first; the two bursts do not overlap.
- Errors and priority: read_req addr=13 → rd_err pulse, no ext. load_start and read_req in the same cycle → load runs and no ext is issued. load_len=0 → no state change.
- Reset mid-read: assert reset during RD_CAPTURE after 2 bytes → out_valid=0 and ext=0 immediately; busy=0; no further out_valid after release.

Source files
------------

// File: rtl/ub_link_pkg.sv
// Shared types and sizing for the unified-buffer host link.
package ub_link_pkg;

  localparam int MEM_SIZE  = 16;
  localparam int BURST_LEN = 4;
  localparam int RD_LAT    = 2;
  localparam int AW        = $clog2(MEM_SIZE);

  // Highest base address whose whole burst still fits in the buffer.
  localparam logic [AW-1:0] RD_ADDR_MAX = AW'(MEM_SIZE - BURST_LEN);
  localparam logic [1:0]    CAP_LAST    = 2'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RD_ISSUE,
    RD_WAIT,
    RD_CAPTURE
  } state_t;

endpackage

// File: rtl/ub_host_link.sv
// Host-side partner of the unified buffer: streams host bytes into the buffer
// and pulls product-matrix bursts back out to the pins.
module ub_host_link
  import ub_link_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load_start,
  input  logic [3:0] load_base,
  input  logic [4:0] load_len,
  input  logic       host_valid,
  input  logic [7:0] host_data,
  output logic       host_ready,
  output logic       load_done,
  input  logic       read_req,
  input  logic [3:0] read_addr,
  output logic       fetch_inp,
  output logic [3:0] dma_address,
  output logic [7:0] ui_in,
  output logic       ext,
  output logic [4:0] ub_addr,
  input  logic [7:0] final_out,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       busy,
  output logic       rd_err
);

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [4:0]    rem_q, rem_d;
  logic [1:0]    cap_q, cap_d;

  logic       host_ready_q, host_ready_d;
  logic       load_done_q, load_done_d;
  logic       fetch_inp_q, fetch_inp_d;
  logic [3:0] dma_address_q, dma_address_d;
  logic [7:0] ui_in_q, ui_in_d;
  logic       ext_q, ext_d;
  logic [4:0] ub_addr_q, ub_addr_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] out_data_q, out_data_d;
  logic       busy_q, busy_d;
  logic       rd_err_q, rd_err_d;

  logic decide, start_load, start_rd, rd_rej, accept;

  // The last capture cycle also acts as an idle decision point so a queued
  // read can re-issue ext exactly when the buffer re-arms.
  assign decide     = (state_q == IDLE) || ((state_q == RD_CAPTURE) && (cap_q == CAP_LAST));
  assign start_load = decide && load_start && (load_len != 5'd0);
  assign start_rd   = decide && !start_load && read_req && (read_addr <= RD_ADDR_MAX);
  assign rd_rej     = decide && !start_load && read_req && (read_addr > RD_ADDR_MAX);
  assign accept     = (state_q == LOAD) && host_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      cap_q   <= cap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    cap_d   = cap_q;
    case (state_q)
      IDLE: ;
      LOAD: begin
        if (accept) begin
          ptr_d = ptr_q + 1'b1;
          rem_d = rem_q - 5'd1;
          if (rem_q == 5'd1) state_d = IDLE;
        end
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        state_d = RD_CAPTURE;
        cap_d   = '0;
      end
      RD_CAPTURE: begin
        cap_d = cap_q + 2'd1;
        if (cap_q == CAP_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (start_load) begin
      state_d = LOAD;
      ptr_d   = load_base;
      rem_d   = load_len;
    end else if (start_rd) begin
      state_d = RD_ISSUE;
    end
  end

  always_comb begin
    host_ready_d  = (state_d == LOAD);
    busy_d        = (state_d != IDLE);
    load_done_d   = 1'b0;
    fetch_inp_d   = 1'b0;
    dma_address_d = dma_address_q;
    ui_in_d       = ui_in_q;
    ext_d         = start_rd;
    ub_addr_d     = ub_addr_q;
    out_valid_d   = 1'b0;
    out_data_d    = out_data_q;
    rd_err_d      = rd_rej;
    if (accept) begin
      fetch_inp_d   = 1'b1;
      dma_address_d = ptr_q;
      ui_in_d       = host_data;
      load_done_d   = (rem_q == 5'd1);
    end
    if (state_q == RD_CAPTURE) begin
      out_valid_d = 1'b1;
      out_data_d  = final_out;
    end
    if (start_rd)               ub_addr_d = {1'b0, read_addr};
    else if (state_d == IDLE)   ub_addr_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      host_ready_q  <= 1'b0;
      load_done_q   <= 1'b0;
      fetch_inp_q   <= 1'b0;
      dma_address_q <= '0;
      ui_in_q       <= '0;
      ext_q         <= 1'b0;
      ub_addr_q     <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      busy_q        <= 1'b0;
      rd_err_q      <= 1'b0;
    end else begin
      host_ready_q  <= host_ready_d;
      load_done_q   <= load_done_d;
      fetch_inp_q   <= fetch_inp_d;
      dma_address_q <= dma_address_d;
      ui_in_q       <= ui_in_d;
      ext_q         <= ext_d;
      ub_addr_q     <= ub_addr_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      busy_q        <= busy_d;
      rd_err_q      <= rd_err_d;
    end
  end

  assign host_ready  = host_ready_q;
  assign load_done   = load_done_q;
  assign fetch_inp   = fetch_inp_q;
  assign dma_address = dma_address_q;
  assign ui_in       = ui_in_q;
  assign ext         = ext_q;
  assign ub_addr     = ub_addr_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign busy        = busy_q;
  assign rd_err      = rd_err_q;

endmodule
